// File: rtl/drive_cali_sequencer.sv
// Per-qubit drive calibration coefficient store and load sequencer.
// Applies one qubit's coefficient set to registered outputs, then flags it valid once it has settled.
module drive_cali_sequencer #(
  parameter int IQ_CALI_WIDTH = 9,
  parameter int NUM_QUBIT     = 8,
  parameter int SETTLE_CYCLES = 2,
  localparam int QID_W        = (NUM_QUBIT > 1) ? $clog2(NUM_QUBIT) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [QID_W-1:0]         cfg_qubit,
  input  logic [2:0]               cfg_field,
  input  logic [IQ_CALI_WIDTH-1:0] cfg_data,
  input  logic                     sel_valid,
  output logic                     sel_ready,
  input  logic [QID_W-1:0]         sel_qubit,
  input  logic                     sel_bypass,
  output logic [IQ_CALI_WIDTH-1:0] alpha_i,
  output logic [IQ_CALI_WIDTH-1:0] beta_i,
  output logic [IQ_CALI_WIDTH-1:0] alpha_q,
  output logic [IQ_CALI_WIDTH-1:0] beta_q,
  output logic [IQ_CALI_WIDTH-1:0] dc_correction,
  output logic                     cali_valid,
  output logic [QID_W-1:0]         active_qubit,
  output logic                     sel_err,
  output logic [1:0]               dbg_state
);

  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [IQ_CALI_WIDTH-1:0] ALPHA_ID = '1;
  localparam logic [IQ_CALI_WIDTH-1:0] ZERO_ID  = '0;

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, ACTIVE} state_t;

  // Handshake: a select transfers on any rising edge where sel_valid && sel_ready;
  // sel_ready is high only while no load/settle is in progress (IDLE or ACTIVE).

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic                       pending;
  logic                       applied_tbl;
  logic                       cap_tbl;
  logic [QID_W-1:0]           cap_qubit;
  logic [IQ_CALI_WIDTH-1:0]   tbl [NUM_QUBIT][5];
  logic [IQ_CALI_WIDTH-1:0]   load_set [5];
  logic                       cfg_ok;
  logic                       sel_in_range;
  logic                       accept;
  logic                       live_hit;

  assign sel_ready    = (state == IDLE) || (state == ACTIVE);
  assign accept       = sel_valid && sel_ready;
  assign sel_in_range = 32'(sel_qubit) < NUM_QUBIT;
  assign cfg_ok       = cfg_we && (cfg_field < 3'd5) && (32'(cfg_qubit) < NUM_QUBIT);
  assign live_hit     = cfg_ok && (cfg_qubit == active_qubit) && applied_tbl &&
                        ((state == SETTLE) || (state == ACTIVE));
  assign dbg_state    = state;

  // A write landing on the LOAD edge is forwarded so the load never applies stale data.
  always_comb begin
    for (int f = 0; f < 5; f++) begin
      load_set[f] = tbl[cap_qubit][f];
      if (cfg_ok && (cfg_qubit == cap_qubit) && (cfg_field == 3'(f)))
        load_set[f] = cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < NUM_QUBIT; q++) begin
        tbl[q][0] <= ALPHA_ID;
        tbl[q][1] <= ZERO_ID;
        tbl[q][2] <= ALPHA_ID;
        tbl[q][3] <= ZERO_ID;
        tbl[q][4] <= ZERO_ID;
      end
    end else begin
      for (int q = 0; q < NUM_QUBIT; q++)
        for (int f = 0; f < 5; f++)
          if (cfg_ok && (cfg_qubit == QID_W'(q)) && (cfg_field == 3'(f)))
            tbl[q][f] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      pending       <= 1'b0;
      applied_tbl   <= 1'b0;
      cap_tbl       <= 1'b0;
      cap_qubit     <= '0;
      alpha_i       <= ALPHA_ID;
      beta_i        <= ZERO_ID;
      alpha_q       <= ALPHA_ID;
      beta_q        <= ZERO_ID;
      dc_correction <= ZERO_ID;
      cali_valid    <= 1'b0;
      active_qubit  <= '0;
      sel_err       <= 1'b0;
    end else begin
      if (live_hit)
        pending <= 1'b1;
      case (state)
        IDLE, ACTIVE: begin
          if (accept) begin
            state      <= LOAD;
            cali_valid <= 1'b0;
            cap_tbl    <= !sel_bypass && sel_in_range;
            cap_qubit  <= sel_in_range ? sel_qubit : active_qubit;
            if (!sel_in_range)
              sel_err <= 1'b1;
          end else if ((state == ACTIVE) && pending) begin
            state      <= LOAD;
            cali_valid <= 1'b0;
            cap_tbl    <= 1'b1;
            cap_qubit  <= active_qubit;
          end
        end
        LOAD: begin
          pending <= 1'b0;
          if (cap_tbl) begin
            alpha_i       <= load_set[0];
            beta_i        <= load_set[1];
            alpha_q       <= load_set[2];
            beta_q        <= load_set[3];
            dc_correction <= load_set[4];
            active_qubit  <= cap_qubit;
            applied_tbl   <= 1'b1;
          end else begin
            alpha_i       <= ALPHA_ID;
            beta_i        <= ZERO_ID;
            alpha_q       <= ALPHA_ID;
            beta_q        <= ZERO_ID;
            dc_correction <= ZERO_ID;
            applied_tbl   <= 1'b0;
          end
          if (SETTLE_CYCLES == 0) begin
            state      <= ACTIVE;
            cali_valid <= 1'b1;
          end else begin
            state <= SETTLE;
            cnt   <= CNT_W'(SETTLE_CYCLES);
          end
        end
        SETTLE: begin
          if (cnt <= CNT_W'(1)) begin
            state      <= ACTIVE;
            cali_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
